// File: rtl/conv_seq_ctrl.sv
// Convolution job sequencer: HPS register slave, tap fetch issue/collect, flush, write and drain.
// Optional WAIT-stall performance counter enabled by defining CONV_SEQ_PERF_EN.
module conv_seq_ctrl #(
  parameter int unsigned KSIZE     = 3,
  parameter int unsigned IN_AW     = 11,
  parameter int unsigned WT_AW     = 17,
  parameter int unsigned OUT_AW    = 15,
  parameter int unsigned IN_STRIDE = 2,
  parameter int unsigned WT_STRIDE = 128,
  parameter int unsigned DRAIN_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              chipselect,
  input  logic              write,
  input  logic [3:0]        address,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [IN_AW-1:0]  addr_input_pe,
  output logic [WT_AW-1:0]  addr_weight_pe,
  output logic [OUT_AW-1:0] addr_write_pe,
  output logic [WT_AW-1:0]  addr_s2p_buffer,
  output logic              input_master_en,
  output logic              weight_master_en,
  output logic              output_master_en,
  input  logic              readdatavalid_input,
  input  logic              readdatavalid_weight,
  output logic              rst_n_pe,
  output logic [3:0]        conv_num,
  output logic              relu_en,
  output logic              pool_en,
  output logic              output_en,
  output logic              partial_en,
  output logic              irq
);

  localparam int unsigned TAP_W = 21;
  localparam int unsigned CH_W  = 11;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned KK    = KSIZE * KSIZE;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_FLUSH = 3'd4,
    S_WRITE = 3'd5,
    S_DRAIN = 3'd6
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [TAP_W-1:0]    r_tap, w_tap_nxt;
  logic [IN_AW-1:0]    r_in_addr, w_in_addr_nxt;
  logic [WT_AW-1:0]    r_wt_addr, w_wt_addr_nxt;
  logic [OUT_AW-1:0]   r_wbase, w_wbase_nxt;
  logic [OUT_AW-1:0]   r_awrite, w_awrite_nxt;
  logic [WT_AW-1:0]    r_s2p, w_s2p_nxt;
  logic [CH_W-1:0]     r_channels, w_channels_nxt;
  logic [3:0]          r_conv, w_conv_nxt;
  logic [3:0]          r_mode, w_mode_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_vin, w_vin_nxt;
  logic                r_vwt, w_vwt_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_err, w_err_nxt;
  logic                r_irq, w_irq_nxt;
  logic                r_pe, w_pe_nxt;
  logic                r_rd_en, w_rd_en_nxt;
  logic                r_wr_en, w_wr_en_nxt;
  logic [31:0]         r_rdata, w_rdata_nxt;

  logic                w_wr, w_rd, w_vin, w_vwt, w_start, w_abort, w_unused_wdata;
  logic [TAP_W-1:0]    w_total, w_tap_inc;
  logic [31:0]         w_perf;

  assign w_wr           = chipselect & write;
  assign w_rd           = chipselect & ~write;
  assign w_vin          = r_vin | readdatavalid_input;
  assign w_vwt          = r_vwt | readdatavalid_weight;
  assign w_total        = TAP_W'(KK) * TAP_W'(r_channels);
  assign w_tap_inc      = r_tap + TAP_W'(1);
  assign w_start        = (r_state == S_IDLE) && w_wr && (address == 4'd1) && writedata[0]
                          && (r_channels != '0);
  assign w_abort        = (r_state != S_IDLE) && w_wr && (address == 4'd6) && writedata[0];
  assign w_unused_wdata = ^writedata;

`ifdef CONV_SEQ_PERF_EN
  logic [31:0] r_perf;

  // Counts WAIT cycles in which the tap is still missing at least one return.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf <= '0;
    end else if (w_start) begin
      r_perf <= '0;
    end else if ((r_state == S_WAIT) && !(w_vin && w_vwt) && (r_perf != '1)) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign w_perf = r_perf;
`else
  assign w_perf = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_tap      <= '0;
      r_in_addr  <= '0;
      r_wt_addr  <= '0;
      r_wbase    <= '0;
      r_awrite   <= '0;
      r_s2p      <= '0;
      r_channels <= '0;
      r_conv     <= 4'hF;
      r_mode     <= '0;
      r_cnt      <= '0;
      r_vin      <= 1'b0;
      r_vwt      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_irq      <= 1'b0;
      r_pe       <= 1'b0;
      r_rd_en    <= 1'b0;
      r_wr_en    <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tap      <= w_tap_nxt;
      r_in_addr  <= w_in_addr_nxt;
      r_wt_addr  <= w_wt_addr_nxt;
      r_wbase    <= w_wbase_nxt;
      r_awrite   <= w_awrite_nxt;
      r_s2p      <= w_s2p_nxt;
      r_channels <= w_channels_nxt;
      r_conv     <= w_conv_nxt;
      r_mode     <= w_mode_nxt;
      r_cnt      <= w_cnt_nxt;
      r_vin      <= w_vin_nxt;
      r_vwt      <= w_vwt_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_irq      <= w_irq_nxt;
      r_pe       <= w_pe_nxt;
      r_rd_en    <= w_rd_en_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_rdata    <= w_rdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_tap_nxt      = r_tap;
    w_in_addr_nxt  = r_in_addr;
    w_wt_addr_nxt  = r_wt_addr;
    w_wbase_nxt    = r_wbase;
    w_awrite_nxt   = r_awrite;
    w_s2p_nxt      = r_s2p;
    w_channels_nxt = r_channels;
    w_conv_nxt     = r_conv;
    w_mode_nxt     = r_mode;
    w_cnt_nxt      = r_cnt;
    w_vin_nxt      = r_vin;
    w_vwt_nxt      = r_vwt;
    w_busy_nxt     = r_busy;
    w_done_nxt     = r_done;
    w_err_nxt      = r_err;
    w_irq_nxt      = 1'b0;
    w_pe_nxt       = r_pe;
    w_rd_en_nxt    = 1'b0;
    w_wr_en_nxt    = 1'b0;
    w_rdata_nxt    = r_rdata;

    // Configuration is frozen while a job runs.
    if (w_wr && !r_busy) begin
      case (address)
        4'd0:    w_conv_nxt     = writedata[3:0];
        4'd2:    w_channels_nxt = writedata[CH_W-1:0];
        4'd3:    w_wbase_nxt    = writedata[OUT_AW-1:0];
        4'd4:    w_s2p_nxt      = writedata[WT_AW-1:0];
        4'd5:    w_mode_nxt     = writedata[3:0];
        default: ;
      endcase
    end

    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt   = S_INIT;
          w_tap_nxt     = '0;
          w_in_addr_nxt = '0;
          w_wt_addr_nxt = '0;
          w_busy_nxt    = 1'b1;
          w_done_nxt    = 1'b0;
          w_err_nxt     = 1'b0;
        end else if (w_wr && (address == 4'd1) && writedata[0]) begin
          w_done_nxt = 1'b0;
          w_err_nxt  = 1'b1;
          w_irq_nxt  = 1'b1;
        end
      end
      S_INIT: begin
        w_state_nxt = S_ISSUE;
        w_vin_nxt   = 1'b0;
        w_vwt_nxt   = 1'b0;
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        w_vin_nxt = w_vin;
        w_vwt_nxt = w_vwt;
        if (w_vin && w_vwt) begin
          w_vin_nxt     = 1'b0;
          w_vwt_nxt     = 1'b0;
          w_tap_nxt     = w_tap_inc;
          w_in_addr_nxt = r_in_addr + IN_AW'(IN_STRIDE);
          w_wt_addr_nxt = r_wt_addr + WT_AW'(WT_STRIDE);
          w_pe_nxt      = 1'b1;
          if (w_tap_inc < w_total) begin
            w_state_nxt = S_ISSUE;
          end else begin
            w_state_nxt = S_FLUSH;
            w_cnt_nxt   = '0;
          end
        end
      end
      S_FLUSH: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_WRITE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_WRITE: begin
        w_state_nxt = S_DRAIN;
        w_cnt_nxt   = '0;
      end
      S_DRAIN: begin
        if (r_cnt == CNT_W'(DRAIN_CYC - 1)) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_irq_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Abort overrides whatever the job was doing this cycle.
    if (w_abort) begin
      w_state_nxt = S_IDLE;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b1;
      w_irq_nxt   = 1'b1;
      w_vin_nxt   = 1'b0;
      w_vwt_nxt   = 1'b0;
      w_cnt_nxt   = '0;
    end

    if ((w_state_nxt == S_IDLE) || (w_state_nxt == S_INIT) || (w_state_nxt == S_DRAIN)) begin
      w_pe_nxt = 1'b0;
    end
    w_rd_en_nxt = (w_state_nxt == S_ISSUE) || (w_state_nxt == S_WAIT);
    w_wr_en_nxt = (w_state_nxt == S_WRITE);
    if (w_state_nxt == S_WRITE) begin
      w_awrite_nxt = r_wbase;
    end

    if (w_rd) begin
      case (address)
        4'd0:    w_rdata_nxt = 32'(r_tap);
        4'd1:    w_rdata_nxt = {29'b0, r_err, r_done, r_busy};
        4'd2:    w_rdata_nxt = 32'(r_channels);
        4'd3:    w_rdata_nxt = 32'(r_wbase);
        4'd4:    w_rdata_nxt = 32'(r_state);
        4'd7:    w_rdata_nxt = w_perf;
        default: w_rdata_nxt = '0;
      endcase
    end
  end

  assign readdata         = r_rdata;
  assign addr_input_pe    = r_in_addr;
  assign addr_weight_pe   = r_wt_addr;
  assign addr_write_pe    = r_awrite;
  assign addr_s2p_buffer  = r_s2p;
  assign input_master_en  = r_rd_en;
  assign weight_master_en = r_rd_en;
  assign output_master_en = r_wr_en;
  assign rst_n_pe         = r_pe;
  assign conv_num         = r_conv;
  assign relu_en          = r_mode[0];
  assign pool_en          = r_mode[1];
  assign output_en        = r_mode[2];
  assign partial_en       = r_mode[3];
  assign irq              = r_irq;

endmodule

// File: doc/conv_seq_ctrl.md
CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 Parameter KSIZE, default 3; kernel edge; taps per channel = KSIZE*KSIZE.
REQ-002 Parameter IN_AW, default 11; input-fetch address width.
REQ-003 Parameter WT_AW, default 17; weight-fetch and s2p address width.
REQ-004 Parameter OUT_AW, default 15; output-write address width.
REQ-005 Parameter IN_STRIDE, default 2; input address increment per tap.
REQ-006 Parameter WT_STRIDE, default 128; weight address increment per tap.
REQ-007 Parameter DRAIN_CYC, default 64; PE pipeline drain cycles after the output write.
REQ-008 clk  in  1  clock; all logic rising-edge.
REQ-009 rst_n  in  1  reset, synchronous, active-low.
REQ-010 chipselect, write  in  1 each  HPS slave strobe and direction.
REQ-011 address  in  4; writedata  in  32; readdata  out  32 (registered).
REQ-012 addr_input_pe  out  IN_AW; addr_weight_pe  out  WT_AW; addr_write_pe  out  OUT_AW; addr_s2p_buffer  out  WT_AW.
REQ-013 input_master_en, weight_master_en, output_master_en  out  1  read/write master requests.
REQ-014 readdatavalid_input, readdatavalid_weight  in  1  master return strobes.
REQ-015 rst_n_pe  out  1  PE accumulator clear, active-low; conv_num  out  4.
REQ-016 relu_en, pool_en, output_en, partial_en  out  1 each  mode flags.
REQ-017 irq  out  1  high one cycle on job completion or error.

Function
REQ-018 Write map: 0 conv_num[3:0]; 1 start (bit0=1); 2 channels[10:0]; 3 write base[OUT_AW-1:0]; 4 s2p base; 5 {partial,output,pool,relu} in bits[3:0]; 6 abort (bit0=1).
REQ-019 Read map (data valid the cycle after the read strobe): 0 tap count; 1 {29'b0,err,done,busy}; 2 channels; 3 write base; 4 state code; 7 perf counter (0 when CONV_SEQ_PERF_EN is undefined); others 0.
REQ-020 States: IDLE(0), INIT(1), ISSUE(2), WAIT(3), FLUSH(4), WRITE(5), DRAIN(6).
REQ-021 IDLE + start with channels>0 -> INIT: clear tap count, input/weight addresses to 0, set busy, clear done/err.
REQ-022 Start with channels==0 -> stay IDLE, set err, pulse irq, no master request.
REQ-023 Start while busy is ignored; config writes while busy are ignored except abort.
REQ-024 ISSUE: one cycle, both read enables high, current addresses driven -> WAIT.
REQ-025 WAIT: enables held; each readdatavalid independently latched; when both latched (same or different cycles) -> clear latches, tap+=1, in_addr+=IN_STRIDE, wt_addr+=WT_STRIDE, modulo widths.
REQ-026 After accepted tap: tap < KSIZE*KSIZE*channels -> ISSUE, else -> FLUSH with read enables low.
REQ-027 rst_n_pe low in IDLE/INIT and until first tap accepted; high thereafter through WRITE; low in DRAIN.
REQ-028 FLUSH: 2 cycles idle -> WRITE.
REQ-029 WRITE: output_master_en high exactly one cycle, addr_write_pe = write base -> DRAIN.
REQ-030 DRAIN: DRAIN_CYC cycles -> IDLE, busy=0, done=1, irq one-cycle pulse.
REQ-031 Tap counter 21 bits; product KSIZE*KSIZE*channels computed at 21 bits, no truncation for channels=2047, KSIZE<=7.
REQ-032 Abort in any non-IDLE state -> IDLE next cycle, all master enables 0, rst_n_pe 0, busy=0, done=0, err=1, irq pulse.

Reset
REQ-033 rst_n low: state IDLE, all master enables 0, rst_n_pe 0, addresses 0, conv_num 15, mode flags 0, channels 0, busy/done/err 0, irq 0, readdata 0, perf counter 0; reset mid-job discards the job.

Configuration
REQ-034 CONV_SEQ_PERF_EN defined: 32-bit saturating counter of WAIT cycles with either valid not yet latched, cleared on start, readable at address 7.
REQ-035 CONV_SEQ_PERF_EN undefined: no counter logic; address 7 reads 0.

Verification
REQ-036 channels=1, valids returned 1 cycle after each request -> 9 taps, weight addrs 0,128..1024, one write pulse, done=1 and irq after DRAIN_CYC.
REQ-037 channels=2, input valid 3 cycles before weight valid each tap -> 18 taps, tap count=18, perf counter=54 with macro.
REQ-038 start with channels=0 -> err=1, irq pulse, no master_en ever high.
REQ-039 abort during tap 5 -> next cycle IDLE, enables 0, status=3'b100; new start runs cleanly.
REQ-040 rst_n low during DRAIN -> all outputs at REQ-033 values next cycle; start while busy -> ignored, tap count unchanged.
